// File: rtl/four_lane_tx_gearbox.sv
// Four-lane 64b/66b TX gearbox.
//
// Takes aligned sets of four 64-bit frames from the frame buffer. For each lane it adds the
// 2-bit sync header and can scramble the payload. It then repacks the 66-bit blocks into
// 32-bit words for four Aurora TX lanes. All lanes share one occupancy counter, so they stay
// block-aligned.
//
// Ports:
//   clk                 block clock (same as frame buffer read clock)
//   reset_n             asynchronous active-low reset
//   present_frame       one-cycle frame request to the frame buffer
//   frames_din[0:3]     64-bit frame per lane, captured when present_frame is high
//   frames_din_service  per-lane type flag: 1 = service/idle, 0 = hit data
//   tx_ready            Aurora lanes accept the current word
//   tx_data[0:3]        32-bit word per lane, MSB transmitted first
//   tx_valid            tx_data valid, common to all lanes
//   mixed_type_err      sticky: a load had differing service flags across lanes
//   block_count         4-lane block sets loaded since reset (wraps)
module four_lane_tx_gearbox #(
    parameter int unsigned SCRAMBLE_EN = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        present_frame,
    input  logic [63:0] frames_din [0:3],
    input  logic [0:3]  frames_din_service,
    input  logic        tx_ready,
    output logic [31:0] tx_data [0:3],
    output logic        tx_valid,
    output logic        mixed_type_err,
    output logic [31:0] block_count
);

    // Shared count of valid bits, left-aligned in every lane buffer (0..97).
    logic [6:0]  occ_q, occ_d;
    logic [6:0]  rem;
    logic        consume;
    logic        load;
    logic        mixed_q;
    logic [31:0] count_q;

    always_comb begin
        tx_valid      = (occ_q >= 7'd32);
        consume       = tx_valid && tx_ready;
        rem           = occ_q - (consume ? 7'd32 : 7'd0);
        // A load always leaves occ >= 66, so two loads can never fall on adjacent cycles.
        load          = (rem < 7'd32);
        present_frame = load;
        occ_d         = rem + (load ? 7'd66 : 7'd0);
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [127:0] buf_q, buf_d;
        logic [57:0]  scr_q, scr_d;
        logic [57:0]  scr_next;
        logic [63:0]  payload;
        logic [65:0]  block;
        logic [127:0] shifted;
        logic [127:0] keep;

        always_comb begin
            scr_next = scr_q;
            payload  = frames_din[g];
            if (SCRAMBLE_EN != 0) begin
                // Self-synchronous x^58+x^39+1, payload bit 63 first; header stays clear.
                for (int b = 63; b >= 0; b--) begin
                    payload[b] = frames_din[g][b] ^ scr_next[38] ^ scr_next[57];
                    scr_next   = {scr_next[56:0], payload[b]};
                end
            end
            block   = {(frames_din_service[g] ? 2'b10 : 2'b01), payload};
            shifted = consume ? {buf_q[95:0], 32'd0} : buf_q;
            // Keep the rem surviving MSBs and place the new block right after them.
            keep    = ~({128{1'b1}} >> rem);
            buf_d   = load ? ((shifted & keep) | ({block, 62'd0} >> rem)) : shifted;
            scr_d   = load ? scr_next : scr_q;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                buf_q <= '0;
                scr_q <= 58'h3FFFFFFFFFFFFFF;
            end else begin
                buf_q <= buf_d;
                scr_q <= scr_d;
            end
        end

        assign tx_data[g] = buf_q[127:96];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q   <= '0;
            mixed_q <= 1'b0;
            count_q <= '0;
        end else begin
            occ_q <= occ_d;
            if (load) begin
                count_q <= count_q + 32'd1;
                if (frames_din_service != 4'b0000 && frames_din_service != 4'b1111) begin
                    mixed_q <= 1'b1;
                end
            end
        end
    end

    assign mixed_type_err = mixed_q;
    assign block_count    = count_q;

endmodule

// File: tb/tb_four_lane_tx_gearbox.sv
// Bench for four_lane_tx_gearbox: two instances (plain and scrambled) share one stimulus.
// They are compared against a bit-queue reference: each load appends 66 header+payload bits
// per lane, and each accepted word removes 32 bits.
module tb_four_lane_tx_gearbox;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] fr [0:3];
    logic [0:3]  svc;
    logic        rdy;

    logic        pf0, pf1, tv0, tv1, me0, me1;
    logic [31:0] td0 [0:3];
    logic [31:0] td1 [0:3];
    logic [31:0] bc0, bc1;

    four_lane_tx_gearbox #(.SCRAMBLE_EN(0)) dut_plain (
        .clk                (clk),
        .reset_n            (reset_n),
        .present_frame      (pf0),
        .frames_din         (fr),
        .frames_din_service (svc),
        .tx_ready           (rdy),
        .tx_data            (td0),
        .tx_valid           (tv0),
        .mixed_type_err     (me0),
        .block_count        (bc0)
    );

    four_lane_tx_gearbox #(.SCRAMBLE_EN(1)) dut_scr (
        .clk                (clk),
        .reset_n            (reset_n),
        .present_frame      (pf1),
        .frames_din         (fr),
        .frames_din_service (svc),
        .tx_ready           (rdy),
        .tx_data            (td1),
        .tx_valid           (tv1),
        .mixed_type_err     (me1),
        .block_count        (bc1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int pulse_cnt = 0;

    // Reference: one entry per transmitted bit position, one bit per lane.
    logic [3:0]  q0 [$];
    logic [3:0]  q1 [$];
    logic [57:0] mscr [0:3];
    logic        mmixed;
    logic [31:0] mcount;
    logic        prev_pf;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int sel, input int lane);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 32; k++) begin
            if (sel == 0) begin
                if (k < q0.size()) w[31-k] = q0[k][lane];
            end else begin
                if (k < q1.size()) w[31-k] = q1[k][lane];
            end
        end
        return w;
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int i = 0; i < 4; i++) mscr[i] = '1;
        mmixed  = 1'b0;
        mcount  = '0;
        prev_pf = 1'b0;
    endtask

    task automatic model_push();
        logic [65:0] b0 [0:3];
        logic [65:0] b1 [0:3];
        logic [63:0] p;
        logic [57:0] s;
        logic [1:0]  hdr;
        logic [3:0]  e0, e1;
        logic        o;
        for (int i = 0; i < 4; i++) begin
            s = mscr[i];
            for (int b = 63; b >= 0; b--) begin
                o    = fr[i][b] ^ s[38] ^ s[57];
                p[b] = o;
                s    = {s[56:0], o};
            end
            mscr[i] = s;
            hdr     = svc[i] ? 2'b10 : 2'b01;
            b0[i]   = {hdr, fr[i]};
            b1[i]   = {hdr, p};
        end
        for (int b = 65; b >= 0; b--) begin
            for (int i = 0; i < 4; i++) begin
                e0[i] = b0[i][b];
                e1[i] = b1[i][b];
            end
            q0.push_back(e0);
            q1.push_back(e1);
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        bit ev, cons, ld;
        int rem;
        #1;
        ev   = (q0.size() >= 32);
        cons = ev && rdy;
        rem  = q0.size() - (cons ? 32 : 0);
        ld   = (rem < 32);
        check("present_frame", pf0, ld);
        check("present_frame_scr", pf1, ld);
        check("tx_valid", tv0, ev);
        check("tx_valid_scr", tv1, ev);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("tx_data%0d", i), td0[i], exp_word(0, i));
            check($sformatf("tx_data_scr%0d", i), td1[i], exp_word(1, i));
        end
        check("mixed_type_err", me0, mmixed);
        check("mixed_type_err_scr", me1, mmixed);
        check("block_count", bc0, mcount);
        check("block_count_scr", bc1, mcount);
        check("pf_spacing", prev_pf & pf0, 0);
        prev_pf   = pf0;
        pulse_cnt += pf0;
        @(posedge clk);
        if (cons) begin
            repeat (32) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
        end
        if (ld) begin
            if (svc != 4'b0000 && svc != 4'b1111) mmixed = 1'b1;
            mcount = mcount + 32'd1;
            model_push();
        end
        @(negedge clk);
    endtask

    // Asserted between clock edges so the asynchronous path is what clears the state.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_tx_valid", tv0, 0);
        check("rst_tx_valid_scr", tv1, 0);
        check("rst_tx_data", td0[0], 0);
        check("rst_mixed", me0, 0);
        check("rst_block_count", bc1, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic rand_frames();
        for (int i = 0; i < 4; i++) fr[i] = {$urandom, $urandom};
    endtask

    initial begin
        rdy = 1'b0;
        svc = 4'b0000;
        for (int i = 0; i < 4; i++) fr[i] = '0;
        model_reset();
        @(negedge clk);

        // Priming with a known hit frame on lane 0.
        do_reset();
        rand_frames();
        fr[0] = 64'h0123456789ABCDEF;
        svc   = 4'b0000;
        rdy   = 1'b1;
        cycle();
        #1 check("first_word_hit", td0[0], 32'h4048D159);
        repeat (5) cycle();

        // Idle frames on every lane.
        do_reset();
        for (int i = 0; i < 4; i++) fr[i] = 64'h1E00000000000000;
        svc = 4'b1111;
        cycle();
        #1;
        for (int i = 0; i < 4; i++) check($sformatf("first_word_idle%0d", i), td0[i], 32'h87800000);
        check("idle_mixed", me0, 0);
        repeat (5) cycle();

        // Steady state: 330 words after priming.
        do_reset();
        rand_frames();
        svc = 4'b0000;
        rdy = 1'b1;
        cycle();
        pulse_cnt = 0;
        repeat (330) begin
            rand_frames();
            svc = ($urandom_range(0, 1) != 0) ? 4'b1111 : 4'b0000;
            cycle();
        end
        #1;
        check("pulses_330", pulse_cnt, 160);
        check("block_count_161", bc0, 161);

        // Mid-stream stall.
        repeat (20) begin rand_frames(); cycle(); end
        rdy       = 1'b0;
        pulse_cnt = 0;
        repeat (10) begin rand_frames(); cycle(); end
        check("stall_no_pulse", pulse_cnt, 0);
        rdy = 1'b1;
        repeat (40) begin rand_frames(); cycle(); end

        // Mixed service flags; the flag must survive later clean loads and clear on reset.
        svc = 4'b0101;
        repeat (3) begin rand_frames(); cycle(); end
        #1 check("mixed_set", me0, 1);
        svc = 4'b0000;
        repeat (50) begin rand_frames(); cycle(); end
        #1 check("mixed_sticky", me1, 1);
        do_reset();

        // Scrambled all-zero hit payload.
        for (int i = 0; i < 4; i++) fr[i] = '0;
        svc = 4'b0000;
        rdy = 1'b1;
        cycle();
        #1 check("first_word_scr_zero", td1[0], 32'h40000000);
        repeat (200) begin
            rdy = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Fully random traffic with occasional resets.
        repeat (1500) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            rand_frames();
            if ($urandom_range(0, 7) == 0) svc = 4'($urandom);
            else svc = ($urandom_range(0, 1) != 0) ? 4'b1111 : 4'b0000;
            rdy = ($urandom_range(0, 4) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/four_lane_tx_gearbox.md
Name: four_lane_tx_gearbox

Overview:
- Sits directly downstream of the four-lane frame buffer, in the same clock domain as the buffer's read side.
- Pulls aligned sets of four 64-bit frames plus service flags by pulsing present_frame.
- For each lane it prepends the 64b/66b sync header, optionally scrambles the payload, and gearboxes 66-bit blocks into 32-bit words for four Aurora TX lanes.
- All four lanes share one occupancy counter, so lanes stay strictly block-aligned.

Parameters:
- SCRAMBLE_EN, 1, 1 = apply the x^58+x^39+1 self-synchronous scrambler to the payload; 0 = pass the payload through unchanged.

Ports:
- clk  input  1  single block clock; same clock as the frame buffer's clk_rd.
- reset_n  input  1  asynchronous, active-low reset.
- present_frame  output  1  frame request to the frame buffer; a one-cycle pulse.
- frames_din[0:3]  input  64 each  frames from the frame buffer; valid whenever present_frame is sampled.
- frames_din_service  input  [0:3]  per-lane frame type: 1 = service/idle, 0 = hit data.
- tx_ready  input  1  Aurora lanes accept the current word.
- tx_data[0:3]  output  32 each  per-lane gearboxed word, MSB transmitted first.
- tx_valid  output  1  tx_data is valid; common to all lanes.
- mixed_type_err  output  1  sticky flag: lanes were loaded with differing service flags.
- block_count  output  32  number of 4-lane block sets loaded since reset; wraps.

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous and active-low.
- Reset values:
  - occ = 0 and all lane buffers = 0.
  - Scrambler state = all ones (58'h3FFFFFFFFFFFFFF).
  - tx_valid = 0, tx_data = 0, mixed_type_err = 0, block_count = 0.
- Reset mid-operation: identical reset state; the partially sent block is discarded and priming restarts.
- Lane buffer:
  - 128-bit left-aligned shift register per lane.
  - occ is a shared 7-bit count of valid bits, range 0..97.
  - tx_data[i] = buffer[i][127:96], driven straight from registers.
  - tx_valid = (occ >= 32).
- Consume and load rule:
  - consume = tx_valid && tx_ready.
  - rem = occ - 32*consume.
  - load = (rem < 32).
  - present_frame = load (combinational from registers and tx_ready).
- Clock-edge update:
  - Buffer shifts left by 32 when consume is set.
  - On load, each lane's 66-bit block is written at bit offset rem from the MSB.
  - occ <= rem + 66*load.
- Block format: bits [65:64] = sync header, transmitted first, followed by payload bit 63 down to bit 0.
  - Service lane: header 2'b10.
  - Hit-data lane: header 2'b01.
- Scrambler (per lane, SCRAMBLE_EN=1):
  - Payload only, processed bit 63 first: out = d ^ s[38] ^ s[57]; s <= {s[56:0], out}.
  - State advances only on load; the header is never scrambled.
- Pulse spacing:
  - After any load occ >= 66, so load is never asserted on two consecutive cycles.
  - This guarantees a low cycle between pulses, as the buffer's rising-edge detector requires.
- Priming and steady state:
  - After reset: occ=0 → load regardless of tx_ready → occ=66 → tx_valid=1 on the next cycle.
  - With tx_ready held high, exactly 16 loads occur per 33 output words, and occ returns to its starting value.
- Stall: while tx_ready=0 with occ >= 32, occ, the buffers and the outputs hold, and present_frame = 0.
- Frame capture: frames_din and frames_din_service are captured on the edge where present_frame=1; the buffer advances on that same edge.
- mixed_type_err: set on any load where frames_din_service is neither 4'b0000 nor 4'b1111; cleared only by reset.
- block_count: increments by 1 on each load and wraps at 2^32.

Test Plan:
- Reset release, SCRAMBLE_EN=0, tx_ready=1, lane 0 hit frame 64'h0123456789ABCDEF → present_frame pulses in cycle 0; first lane-0 word 32'h4048D159.
- Idle frames 64'h1E00000000000000 with service=4'b1111, SCRAMBLE_EN=0 → first word on every lane 32'h87800000; mixed_type_err stays 0.
- tx_ready=1 for 330 cycles after priming → exactly 160 present_frame pulses, never in adjacent cycles; block_count = 161.
- Drop tx_ready for 10 cycles mid-stream → tx_data, occ and present_frame are frozen; the resumed word sequence is identical to an unstalled run.
- Load with service=4'b0101 → mixed_type_err=1 and stays set through later valid loads; reset_n low → cleared asynchronously.
- SCRAMBLE_EN=1 with an all-zero hit payload → payload bits match a reference scrambler seeded all ones; the 2'b01 header appears unscrambled every 66 bits.
